picomips_sequencer: RTL and testbench

Multi-cycle control sequencer for the picoMIPS core. It fetches instructions from program memory over a req/ack handshake and holds them in an instruction register that feeds the combinational decoder. It then steps each instruction through DECODE, EXEC and WB states, turning the decoder's level outputs into single-cycle PC-load, flag-write and register-write strobes. It also handles start/halt control and keeps a retired-instruction counter.

---
 rtl/picomips_sequencer.sv | 124 ++++++++++++
 tb/tb_picomips_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/picomips_sequencer.sv
// Multi-cycle control sequencer for picoMIPS: fetches over a req/ack handshake,
// holds the instruction register and steps FETCH/DECODE/EXEC/WB with one-cycle strobes.
module picomips_sequencer #(
    parameter int         IW      = 24,
    parameter logic [5:0] HALT_OP = 6'h3F,
    parameter int         CW      = 16
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          start,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] ir,
    input  logic          PCincr,
    input  logic          PCabsbranch,
    input  logic          PCrelbranch,
    input  logic          w,
    output logic          pc_ld,
    output logic [1:0]    pc_sel,
    output logic          flags_we,
    output logic          reg_we,
    output logic          halted,
    output logic [CW-1:0] icount
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALTED
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [5:0] opcode;

    assign opcode = ir[IW-1:IW-6];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are pure state decodes; only the WB-cycle PC/register strobes
    // look through to the decoder, whose inputs are stable by then.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        flags_we   = 1'b0;
        reg_we     = 1'b0;
        pc_ld      = 1'b0;
        pc_sel     = 2'b00;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (opcode == HALT_OP) begin
                    next_state = HALTED;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                flags_we   = 1'b1;
                next_state = WB;
            end
            WB: begin
                reg_we = w;
                pc_ld  = PCabsbranch | PCrelbranch | PCincr;
                if (PCabsbranch) begin
                    pc_sel = 2'b01;
                end else if (PCrelbranch) begin
                    pc_sel = 2'b10;
                end else begin
                    pc_sel = 2'b00;
                end
                next_state = FETCH;
            end
            HALTED: begin
                halted = 1'b1;
                if (start) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ir <= '0;
        end else if (state == FETCH && imem_ack) begin
            ir <= imem_rdata;
        end
    end

    // Counts on the WB edge so a halt instruction never retires.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            icount <= '0;
        end else if (state == WB) begin
            icount <= icount + CW'(1);
        end
    end

endmodule

// File: tb/tb_picomips_sequencer.sv
// Randomized self-checking bench for picomips_sequencer; a per-instruction timeline
// model predicts every cycle of fetch, decode, exec, writeback and halt.
module tb_picomips_sequencer;

    localparam int         IW      = 24;
    localparam int         CW      = 4;
    localparam logic [5:0] HALT_OP = 6'h3F;

    logic          clk = 1'b0;
    logic          nReset;
    logic          start;
    logic          imem_req;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] ir;
    logic          PCincr;
    logic          PCabsbranch;
    logic          PCrelbranch;
    logic          w;
    logic          pc_ld;
    logic [1:0]    pc_sel;
    logic          flags_we;
    logic          reg_we;
    logic          halted;
    logic [CW-1:0] icount;

    int            total = 0;
    int            bad = 0;
    logic [IW-1:0] expIr;
    logic [CW-1:0] expCount;

    picomips_sequencer #(.IW(IW), .HALT_OP(HALT_OP), .CW(CW)) dut (
        .clk(clk), .nReset(nReset), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
        .PCincr(PCincr), .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch), .w(w),
        .pc_ld(pc_ld), .pc_sel(pc_sel), .flags_we(flags_we), .reg_we(reg_we),
        .halted(halted), .icount(icount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_outs"}, 32'({imem_req, pc_ld, pc_sel, flags_we, reg_we, halted}), 32'd0);
        checkOutput({tag, "_ir"}, 32'(ir), 32'd0);
        checkOutput({tag, "_icount"}, 32'(icount), 32'd0);
    endtask

    // Entered one step after the edge that put the DUT into FETCH; leaves it the
    // same way (or in HALTED when the opcode is the halt opcode).
    task automatic applyStimulus(input logic [5:0] op, input int delay,
                                 input logic incr, input logic abs, input logic rel, input logic wv);
        logic [31:0]   rnd;
        logic [IW-1:0] word;
        logic          expLd;
        logic [1:0]    expSel;
        int            cycles;
        rnd    = $urandom;
        word   = {op, rnd[IW-7:0]};
        PCincr = incr; PCabsbranch = abs; PCrelbranch = rel; w = wv;
        expLd  = incr | abs | rel;
        expSel = abs ? 2'b01 : (rel ? 2'b10 : 2'b00);
        cycles = 0;
        for (int k = 0; k < delay; k++) begin
            checkOutput("wait_req", 32'(imem_req), 32'd1);
            checkOutput("wait_ir", 32'(ir), 32'(expIr));
            imem_ack = 1'b0; imem_rdata = IW'($urandom); start = 1'($urandom);
            tick(); cycles++;
        end
        checkOutput("fetch_req", 32'(imem_req), 32'd1);
        checkOutput("fetch_strobes", 32'({pc_ld, flags_we, reg_we, halted}), 32'd0);
        checkOutput("fetch_ir", 32'(ir), 32'(expIr));
        imem_ack = 1'b1; imem_rdata = word; start = 1'($urandom);
        tick(); cycles++;
        expIr = word;
        imem_ack = 1'($urandom); imem_rdata = IW'($urandom); start = 1'($urandom);
        checkOutput("dec_ir", 32'(ir), 32'(expIr));
        checkOutput("dec_outs", 32'({imem_req, pc_ld, flags_we, reg_we, halted}), 32'd0);
        tick(); cycles++;
        if (op == HALT_OP) begin
            checkOutput("halt_outs", 32'({imem_req, pc_ld, flags_we, reg_we, halted}), 32'd1);
            checkOutput("halt_icount", 32'(icount), 32'(expCount));
            checkOutput("halt_ir", 32'(ir), 32'(expIr));
            start = 1'b0; imem_ack = 1'b0;
            return;
        end
        imem_ack = 1'($urandom); start = 1'($urandom);
        checkOutput("exec_outs", 32'({imem_req, pc_ld, flags_we, reg_we, halted}), 32'b00100);
        tick(); cycles++;
        imem_ack = 1'($urandom); start = 1'($urandom);
        checkOutput("wb_pc_ld", 32'(pc_ld), 32'(expLd));
        if (expLd) checkOutput("wb_pc_sel", 32'(pc_sel), 32'(expSel));
        checkOutput("wb_reg_we", 32'(reg_we), 32'(wv));
        checkOutput("wb_others", 32'({imem_req, flags_we, halted}), 32'd0);
        checkOutput("wb_icount", 32'(icount), 32'(expCount));
        tick(); cycles++;
        imem_ack = 1'b0; start = 1'b0;
        expCount = expCount + 1'b1;
        checkOutput("next_req", 32'(imem_req), 32'd1);
        checkOutput("next_strobes", 32'({pc_ld, flags_we, reg_we, halted}), 32'd0);
        checkOutput("icount", 32'(icount), 32'(expCount));
        checkOutput("instr_cycles", 32'(cycles), 32'(4 + delay));
    endtask

    task automatic restartFromHalt(input int idleCycles);
        for (int k = 0; k < idleCycles; k++) begin
            start = 1'b0; imem_ack = 1'($urandom);
            tick();
            checkOutput("halted_hold", 32'({imem_req, halted}), 32'b01);
            checkOutput("halted_ir", 32'(ir), 32'(expIr));
        end
        start = 1'b1; imem_ack = 1'b0;
        tick();
        start = 1'b0;
        checkOutput("restart", 32'({imem_req, halted}), 32'b10);
    endtask

    task automatic idleAfterReset();
        for (int k = 0; k < 10; k++) begin
            tick();
            checkIdleOutputs("idle");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_req", 32'(imem_req), 32'd1);
    endtask

    initial begin
        logic [5:0] op;
        logic [3:0] f;
        nReset = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0; w = 1'b0;
        expIr = '0; expCount = '0;
        tick(); tick();
        checkIdleOutputs("in_reset");
        nReset = 1'b1;
        idleAfterReset();

        applyStimulus(6'h01, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'h02, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'h04, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'h05, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(6'h06, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(HALT_OP, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        restartFromHalt(3);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? HALT_OP : 6'($urandom_range(0, 62));
            f  = 4'($urandom);
            applyStimulus(op, $urandom_range(0, 3), f[0], f[1], f[2], f[3]);
            if (op == HALT_OP) restartFromHalt($urandom_range(0, 3));
        end

        applyStimulus(6'h11, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 nReset = 1'b0;
        #1;
        checkIdleOutputs("async_reset");
        tick();
        #2 nReset = 1'b1;
        expIr = '0; expCount = '0;
        idleAfterReset();
        applyStimulus(6'h03, 1, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
